// File: rtl/conv3d_fold.sv
// conv3d_fold: output-channel-folded 3D convolution, PAR_OUT kernels per beat, bias, rounding requant, ReLU/saturation
module conv3d_fold #(
  parameter int DIN_WIDTH    = 8,
  parameter int KERN_WIDTH   = 16,
  parameter int BIAS_WIDTH   = 24,
  parameter int DOUT_WIDTH   = 8,
  parameter int WIN_SIZE     = 3,
  parameter int CHANNELS_IN  = 4,
  parameter int CHANNELS_OUT = 128,
  parameter int PAR_OUT      = 16,
  parameter int SHIFT_MAX    = 31
) (
  input  logic                                                            clk,
  input  logic                                                            reset_n,
  input  logic [CHANNELS_OUT*CHANNELS_IN*WIN_SIZE*WIN_SIZE*KERN_WIDTH-1:0] kernel,
  input  logic [CHANNELS_OUT*BIAS_WIDTH-1:0]                               bias,
  input  logic [$clog2(SHIFT_MAX):0]                                       shift,
  input  logic                                                            relu_en,
  input  logic                                                            fin_start,
  input  logic                                                            win_vld,
  output logic                                                            win_rdy,
  input  logic [WIN_SIZE*WIN_SIZE*CHANNELS_IN*DIN_WIDTH-1:0]               window,
  output logic                                                            fout_start,
  output logic                                                            dout_vld,
  input  logic                                                            dout_rdy,
  output logic [$clog2(CHANNELS_OUT/PAR_OUT):0]                            dout_grp,
  output logic                                                            dout_last,
  output logic [PAR_OUT*DOUT_WIDTH-1:0]                                    dout
);
  localparam int GROUPS = CHANNELS_OUT / PAR_OUT;
  localparam int N      = CHANNELS_IN * WIN_SIZE * WIN_SIZE;
  localparam int PROD_W = DIN_WIDTH + KERN_WIDTH + 1 + $clog2(N);
  localparam int ACC_W  = (PROD_W > BIAS_WIDTH ? PROD_W : BIAS_WIDTH) + 1;
  localparam int GW     = $clog2(GROUPS) + 1;
  localparam int SW     = $clog2(SHIFT_MAX) + 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);
  localparam logic signed [ACC_W:0] UMAX = (ACC_W+1)'((1 << DOUT_WIDTH) - 1);
  localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'((1 << (DOUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W:0] SMIN = ~SMAX;
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  if (CHANNELS_OUT % PAR_OUT != 0) begin : g_bad_fold
    $error("CHANNELS_OUT must be a multiple of PAR_OUT");
  end
  logic                                               state;
  logic                                               sof;
  logic [GW-1:0]                                      grp;
  logic [WIN_SIZE*WIN_SIZE*CHANNELS_IN*DIN_WIDTH-1:0] win_q;
  logic [PAR_OUT*DOUT_WIDTH-1:0]                      res;
  logic signed [ACC_W-1:0]                            acc;
  logic signed [ACC_W:0]                              rnd;
  logic signed [ACC_W:0]                              rr;
  logic                                               load;
  int                                                 c;
  assign win_rdy = state == IDLE;
  assign load    = state == RUN && (!dout_vld || dout_rdy);
  assign rnd     = shift == '0 ? '0 : (ACC_W+1)'(1) << (shift - SW'(1));
  // Window pixels are unsigned: a zero MSB makes the signed multiply exact.
  always_comb begin
    res = '0;
    acc = '0;
    rr  = '0;
    c   = 0;
    for (int p = 0; p < PAR_OUT; p++) begin
      c   = int'(grp) * PAR_OUT + p;
      acc = ACC_W'($signed(bias[c*BIAS_WIDTH +: BIAS_WIDTH]));
      for (int ci = 0; ci < CHANNELS_IN; ci++)
        for (int y = 0; y < WIN_SIZE; y++)
          for (int x = 0; x < WIN_SIZE; x++)
            acc = acc + ACC_W'($signed({1'b0, win_q[((y*WIN_SIZE+x)*CHANNELS_IN+ci)*DIN_WIDTH +: DIN_WIDTH]})
                      * $signed(kernel[(c*N + (ci*WIN_SIZE+y)*WIN_SIZE+x)*KERN_WIDTH +: KERN_WIDTH]));
      rr = ((ACC_W+1)'(acc) + rnd) >>> shift;
      res[p*DOUT_WIDTH +: DOUT_WIDTH] = relu_en
        ? (rr[ACC_W] ? '0 : rr > UMAX ? UMAX[DOUT_WIDTH-1:0] : rr[DOUT_WIDTH-1:0])
        : (rr < SMIN ? SMIN[DOUT_WIDTH-1:0] : rr > SMAX ? SMAX[DOUT_WIDTH-1:0] : rr[DOUT_WIDTH-1:0]);
    end
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state      <= IDLE;
      sof        <= 1'b0;
      grp        <= '0;
      win_q      <= '0;
      dout_vld   <= 1'b0;
      fout_start <= 1'b0;
      dout_last  <= 1'b0;
      dout_grp   <= '0;
      dout       <= '0;
    end else begin
      if (win_vld && win_rdy) begin
        state <= RUN;
        win_q <= window;
        sof   <= fin_start;
        grp   <= '0;
      end
      if (load) begin
        dout       <= res;
        dout_vld   <= 1'b1;
        dout_grp   <= grp;
        dout_last  <= grp == LAST_GRP;
        fout_start <= sof && grp == '0;
        grp        <= grp == LAST_GRP ? '0 : grp + GW'(1);
        state      <= grp == LAST_GRP ? IDLE : RUN;
      end else if (dout_rdy)
        dout_vld <= 1'b0;
    end
endmodule
